// File: rtl/drop_pkg.sv
// Shared constants and the level-to-threshold mapping for the gravity step controller.
package drop_pkg;

  localparam int unsigned EDGES_MAX_DEF = 8;
  localparam int unsigned FAST_DIV_DEF  = 10000000;
  localparam int unsigned MISSED_MAX    = 15;

  // Slow-clock edges needed per gravity step; never below one.
  function automatic int unsigned calc_thr(input int unsigned edges_max,
                                           input int unsigned level);
    if (level >= edges_max) return 1;
    return edges_max - level;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings the slow toggling clock into clk100m and emits a registered pulse on each of its edges.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk100m,
  input  logic rst_n,
  input  logic slow_clk,
  output logic edge_pulse
);

  localparam int unsigned PW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [PW-1:0]          prime_cnt_q;
  logic                   primed_q;
  logic                   edge_pulse_q;

  // History starts at 0, so a high slow_clk at release looks like an edge until primed.
  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      hist_q       <= 1'b0;
      prime_cnt_q  <= '0;
      primed_q     <= 1'b0;
      edge_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      hist_q       <= sync_q[SYNC_STAGES-1];
      if (!primed_q) prime_cnt_q <= prime_cnt_q + PW'(1);
      primed_q     <= primed_q | (prime_cnt_q == PW'(SYNC_STAGES));
      edge_pulse_q <= primed_q & (hist_q ^ sync_q[SYNC_STAGES-1]);
    end
  end

  assign edge_pulse = edge_pulse_q;

endmodule

// File: rtl/drop_step_ctrl.sv
// Turns slow-clock edges (or a fast soft-drop timer) into gravity steps offered over req/ack.
module drop_step_ctrl
  import drop_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEVEL_W     = 4,
  parameter int unsigned EDGES_MAX   = EDGES_MAX_DEF,
  parameter int unsigned FAST_DIV    = FAST_DIV_DEF,
  parameter int unsigned FAST_W      = 24
) (
  input  logic               clk100m,
  input  logic               rst_n,
  input  logic               slow_clk,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               pause,
  input  logic               step_ack,
  input  logic               clear_missed,
  output logic               step_req,
  output logic               edge_pulse,
  output logic [3:0]         missed_steps
);

  localparam int unsigned GW = $clog2(EDGES_MAX + 1);

  logic [GW-1:0]     g_cnt_q, g_cnt_d;
  logic [GW:0]       g_inc;
  logic [FAST_W-1:0] f_cnt_q, f_cnt_d;
  logic              step_req_q, step_req_d;
  logic [3:0]        missed_q, missed_d;
  logic              grav_evt, fast_evt, evt, miss;
  int unsigned       thr;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk100m   (clk100m),
    .rst_n     (rst_n),
    .slow_clk  (slow_clk),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    thr      = calc_thr(EDGES_MAX, 32'(level));
    g_inc    = {1'b0, g_cnt_q} + (GW + 1)'(1);
    g_cnt_d  = g_cnt_q;
    f_cnt_d  = f_cnt_q;
    grav_evt = 1'b0;
    fast_evt = 1'b0;
    if (!soft_drop) begin
      f_cnt_d = '0;
      // >= so a level change that lowers thr below the count fires on the next edge.
      if (!pause && edge_pulse) begin
        if (32'(g_inc) >= thr) begin
          grav_evt = 1'b1;
          g_cnt_d  = '0;
        end else begin
          g_cnt_d = g_inc[GW-1:0];
        end
      end
    end else begin
      g_cnt_d = '0;
      if (!pause) begin
        if (f_cnt_q == FAST_W'(FAST_DIV - 1)) begin
          fast_evt = 1'b1;
          f_cnt_d  = '0;
        end else begin
          f_cnt_d = f_cnt_q + FAST_W'(1);
        end
      end
    end
  end

  // A new event coinciding with an ack re-arms the request instead of counting as a miss.
  always_comb begin
    evt        = grav_evt | fast_evt;
    miss       = 1'b0;
    step_req_d = step_req_q;
    if (evt) begin
      if (!step_req_q || step_ack) step_req_d = 1'b1;
      else                         miss       = 1'b1;
    end else if (step_ack) begin
      step_req_d = 1'b0;
    end

    missed_d = missed_q;
    if (clear_missed) begin
      missed_d = miss ? 4'd1 : 4'd0;
    end else if (miss && missed_q != 4'(MISSED_MAX)) begin
      missed_d = missed_q + 4'd1;
    end
  end

  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt_q    <= '0;
      f_cnt_q    <= '0;
      step_req_q <= 1'b0;
      missed_q   <= '0;
    end else begin
      g_cnt_q    <= g_cnt_d;
      f_cnt_q    <= f_cnt_d;
      step_req_q <= step_req_d;
      missed_q   <= missed_d;
    end
  end

  assign step_req     = step_req_q;
  assign missed_steps = missed_q;

endmodule

// File: doc/drop_step_ctrl.md
Name: drop_step_ctrl

Overview:
- Consumer end of the slow toggling game clock produced by the 100 MHz divider.
- Synchronises the slow toggle into the clk100m domain and detects both of its edges.
- Converts those edges into level-scaled gravity steps, with a soft-drop fast-rate override and pause.
- Presents each step to the Tetris game FSM over a req/ack handshake.

Parameters:
SYNC_STAGES, 2, synchroniser flops on slow_clk (min 2)
LEVEL_W, 4, width of level input
EDGES_MAX, 8, slow edges per step at level 0
FAST_DIV, 10000000, clk100m cycles per soft-drop step (100 ms)
FAST_W, 24, width of fast counter (must hold FAST_DIV-1)

Ports:
clk100m  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
slow_clk  in  1  toggling slow clock from divider, asynchronous to clk100m
level  in  LEVEL_W  game level; higher level means faster gravity
soft_drop  in  1  held high for fast drop
pause  in  1  freeze step generation
step_ack  in  1  game FSM consumed step
clear_missed  in  1  clears missed_steps
step_req  out  1  pending gravity step
edge_pulse  out  1  one-cycle pulse per synchronised slow_clk edge
missed_steps  out  4  saturating count of dropped steps

Behaviour:
- Reset (async assert, sync release): all flops 0. step_req=0, edge_pulse=0, missed_steps=0, primed=0.
- Sync/edge: slow_clk passes through SYNC_STAGES flops, then one history flop.
  - edge = history XOR sync output, counting rising and falling edges.
  - edge_pulse is registered. Latency from slow_clk transition to edge_pulse is SYNC_STAGES+1 cycles, ±1 cycle for sampling uncertainty.
- Priming: edges are suppressed until SYNC_STAGES+1 cycles after reset release. This prevents a false edge when slow_clk=1 at reset release.
- Threshold: thr = EDGES_MAX - level, clamped to a minimum of 1 (level ≥ EDGES_MAX gives thr=1). Evaluated combinationally every cycle.
- Gravity counter g_cnt:
  - Counts edge_pulse while pause=0 and soft_drop=0.
  - When an edge occurs with g_cnt+1 ≥ thr, raise grav_evt and set g_cnt=0.
  - If level drops thr below g_cnt, the step fires on the next edge.
- Fast counter f_cnt:
  - Runs only while soft_drop=1 and pause=0. Wraps at FAST_DIV-1 and raises fast_evt on the wrap.
  - Reset to 0 while soft_drop=0.
  - g_cnt is held at 0 while soft_drop=1.
  - On soft_drop deassert, gravity restarts from count 0.
- Pause: both counters hold their value and no events are generated. edge_pulse continues. A pending step_req stays asserted and can still be acked.
- evt = grav_evt | fast_evt. Both are mutually exclusive by construction.
- Handshake:
  - step_req sets on the cycle after evt and stays high until step_ack=1 is sampled; it clears the following cycle.
  - evt in the same cycle as an ack: step_req stays high (new request). No miss is counted.
  - evt while step_req=1 with no ack that cycle: the event is dropped and missed_steps increments, saturating at 15.
  - step_ack while step_req=0 is ignored.
- clear_missed=1 sets missed_steps=0 next cycle. If clear and miss occur in the same cycle, the result is 1.
- Reset mid-operation clears all state, including a pending step_req, and re-enters priming.

Decomposition:
- Package drop_pkg:
  - EDGES_MAX and FAST_DIV defaults.
  - MISSED_MAX=15.
  - A function computing clamped thr from level.
- Sub-module sync_edge_det (params SYNC_STAGES): synchroniser, history flop, priming, registered edge_pulse.
- Counters and handshake live in drop_step_ctrl.

Test Plan:
(Bench uses EDGES_MAX=4, FAST_DIV=8, SYNC_STAGES=2.)
1. Reset with slow_clk=1, release, hold 10 cycles -> edge_pulse never asserts; step_req=0. Then toggle slow_clk once -> exactly one edge_pulse 3±1 cycles later.
2. level=0, toggle slow_clk 8 times, 40 cycles apart, with step_ack pulsed on each step_req -> exactly 2 step_req assertions, one after the 4th edge and one after the 8th. level=3 -> a step on every edge. level=15 -> a step on every edge (clamp).
3. soft_drop=1, step_ack tied high, run 64 cycles -> 8 step_req pulses spaced 8 cycles apart; slow_clk edges cause no extra steps. Deassert -> next step after 4 edges.
4. level=3, step_ack tied 0, 20 slow edges -> step_req stays high, missed_steps=15 (saturated). clear_missed -> 0. Ack coincident with an event -> step_req remains 1 and missed unchanged.
5. pause=1 mid-count (g_cnt=2, level 0), 6 edges -> no step, edge_pulse still seen. pause=0, 2 edges -> step. Ack during pause clears a pending req.
6. Assert rst_n=0 while step_req=1 and f_cnt=5 -> step_req, missed_steps, and counters read 0 immediately, without waiting for a clock edge.
